// File: rtl/instr_fetch.sv
// Instruction fetch stage. Issues one memory request per accepted PC and
// tracks it through a small FSM. Returned words are queued with their PCs in
// a DEPTH-entry FIFO. The FIFO head is held in registers, so id_* stay put
// whenever the FIFO is empty.
//
// Handshakes:
//  - Memory side: imem_req/imem_addr are raised on an accept edge. They stay
//    unchanged until the edge where imem_ack is sampled high, and imem_ack is
//    ignored while imem_req is low.
//  - Decode side: a head entry transfers on any edge where id_valid and
//    id_ready are both high and flush is low.
//  - PC side: pc_taken pulses for one cycle after the edge that captured pc_in.
module instr_fetch #(
  parameter int DEPTH     = 2,
  parameter int BYTE_ADDR = 0
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        pc_taken,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     fpc_q, fpc_d;
  logic            taken_q, taken_d;
  logic            valid_q, valid_d;
  logic [31:0]     hpc_q, hpc_d;
  logic [31:0]     hinstr_q, hinstr_d;
  logic [31:0]     pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  logic            pop, push, accept;
  logic [CW-1:0]   occ_next;

  // Transfer qualifiers; accept reserves a FIFO slot for the new request.
  always_comb begin
    pop      = valid_q & id_ready & ~flush;
    push     = imem_ack & (state_q == S_WAIT) & ~flush;
    occ_next = count_q + CW'(push) - CW'(pop);
    accept   = ~flush
             & ((state_q == S_IDLE) | ((state_q == S_WAIT) & imem_ack))
             & (occ_next < CW'(DEPTH));
  end

  // Next-state logic for the request FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (flush)         state_d = imem_ack ? S_IDLE : S_DROP;
        else if (imem_ack) state_d = accept ? S_WAIT : S_IDLE;
      end
      S_DROP: if (imem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request address, in-flight PC, and the PC-taken pulse.
  always_comb begin
    addr_d  = addr_q;
    fpc_d   = fpc_q;
    taken_d = accept;
    if (accept) begin
      fpc_d  = pc_in;
      addr_d = (BYTE_ADDR != 0) ? {pc_in[29:0], 2'b00} : pc_in;
    end
  end

  // FIFO pointers, occupancy, and the registered head view.
  always_comb begin
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = occ_next;
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
    end
    valid_d  = (count_d != '0);
    hpc_d    = hpc_q;
    hinstr_d = hinstr_q;
    if (count_d != '0) begin
      // The slot being written this edge becomes the head only if the FIFO
      // is otherwise empty. A full FIFO cannot push, so pointer equality
      // identifies that case unambiguously.
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        hpc_d    = fpc_q;
        hinstr_d = imem_rdata;
      end else begin
        hpc_d    = pc_mem_q[rd_ptr_d];
        hinstr_d = instr_mem_q[rd_ptr_d];
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      addr_q   <= '0;
      fpc_q    <= '0;
      taken_q  <= 1'b0;
      valid_q  <= 1'b0;
      hpc_q    <= '0;
      hinstr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      addr_q   <= addr_d;
      fpc_q    <= fpc_d;
      taken_q  <= taken_d;
      valid_q  <= valid_d;
      hpc_q    <= hpc_d;
      hinstr_q <= hinstr_d;
    end
  end

  // FIFO storage; contents are only read once count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fpc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = addr_q;
  assign pc_taken  = taken_q;
  assign id_valid  = valid_q;
  assign id_pc     = hpc_q;
  assign id_instr  = hinstr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (DEPTH=2, byte addressing).
module tb_instr_fetch;

  logic        clk;
  logic        clr_n;
  logic [31:0] pc_in;
  logic        flush;
  logic        pc_taken;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rd;
    logic        rdy;
    logic        fl;
    logic        req;
    logic [31:0] addr;
    logic        tk;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] iin;
  } vec_t;

  vec_t tbl[16];

  instr_fetch #(.DEPTH(2), .BYTE_ADDR(1)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .pc_in      (pc_in),
    .flush      (flush),
    .pc_taken   (pc_taken),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_ready   (id_ready),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic ack,
                       input logic [31:0] rd, input logic rdy, input logic fl);
    pc_in      = pc;
    imem_ack   = ack;
    imem_rdata = rd;
    id_ready   = rdy;
    flush      = fl;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Streaming, latency and backpressure vectors, applied from reset release.
    tbl[0]  = '{32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 32'h0,  32'h0};
    tbl[1]  = '{32'h10, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0};
    tbl[2]  = '{32'h10, 1'b1, 32'hA0000000, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h0,  32'hA0000000};
    tbl[3]  = '{32'h10, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'hA0000000};
    tbl[4]  = '{32'h10, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'hA0000000};
    tbl[5]  = '{32'h0,  1'b1, 32'hC0DE0010, 1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 32'h10, 32'hC0DE0010};
    tbl[6]  = '{32'h1,  1'b1, 32'hB0000000, 1'b1, 1'b0, 1'b1, 32'h4,  1'b1, 1'b1, 32'h0,  32'hB0000000};
    tbl[7]  = '{32'h2,  1'b1, 32'hB0000001, 1'b1, 1'b0, 1'b1, 32'h8,  1'b1, 1'b1, 32'h1,  32'hB0000001};
    tbl[8]  = '{32'h3,  1'b1, 32'hB0000002, 1'b1, 1'b0, 1'b1, 32'hC,  1'b1, 1'b1, 32'h2,  32'hB0000002};
    tbl[9]  = '{32'h4,  1'b1, 32'hB0000003, 1'b0, 1'b0, 1'b0, 32'hC,  1'b0, 1'b1, 32'h2,  32'hB0000002};
    tbl[10] = '{32'h4,  1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'hC,  1'b0, 1'b1, 32'h2,  32'hB0000002};
    tbl[11] = '{32'h4,  1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h3,  32'hB0000003};
    tbl[12] = '{32'h5,  1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h3,  32'hB0000003};
    tbl[13] = '{32'h5,  1'b1, 32'hB0000004, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h3,  32'hB0000003};
    tbl[14] = '{32'h5,  1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 32'h4,  32'hB0000004};
    tbl[15] = '{32'h6,  1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 1'b0, 32'h4,  32'hB0000004};

    // Reset with arbitrary inputs
    clr_n = 1'b0;
    drive(32'h55, 1'b1, 32'h12345678, 1'b1, 1'b0);
    repeat (3) step();
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_taken", {31'b0, pc_taken}, 32'h0);
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_idpc",  id_pc, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, 32'h0);

    // Table-driven vectors
    clr_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].pc, tbl[i].ack, tbl[i].rd, tbl[i].rdy, tbl[i].fl);
      step();
      chk($sformatf("row%0d_req", i),   {31'b0, imem_req}, {31'b0, tbl[i].req});
      chk($sformatf("row%0d_addr", i),  imem_addr,         tbl[i].addr);
      chk($sformatf("row%0d_taken", i), {31'b0, pc_taken}, {31'b0, tbl[i].tk});
      chk($sformatf("row%0d_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].vld});
      chk($sformatf("row%0d_idpc", i),  id_pc,             tbl[i].ipc);
      chk($sformatf("row%0d_instr", i), id_instr,          tbl[i].iin);
    end

    // Flush while waiting without ack: go to DROP, discard the late data
    drive(32'h20, 1'b0, 32'h0, 1'b0, 1'b1);
    step();
    chk("fw_req",   {31'b0, imem_req}, 32'h1);
    chk("fw_addr",  imem_addr, 32'h14);
    chk("fw_taken", {31'b0, pc_taken}, 32'h0);
    chk("fw_state", {30'b0, dbg_state}, 32'h2);
    chk("fw_valid", {31'b0, id_valid}, 32'h0);
    drive(32'h20, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("drop_state", {30'b0, dbg_state}, 32'h2);
    chk("drop_req",   {31'b0, imem_req}, 32'h1);
    chk("drop_taken", {31'b0, pc_taken}, 32'h0);
    drive(32'h20, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    step();
    chk("dack_req",   {31'b0, imem_req}, 32'h0);
    chk("dack_taken", {31'b0, pc_taken}, 32'h0);
    chk("dack_valid", {31'b0, id_valid}, 32'h0);
    chk("dack_state", {30'b0, dbg_state}, 32'h0);
    drive(32'h20, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("redir_addr",  imem_addr, 32'h80);
    chk("redir_taken", {31'b0, pc_taken}, 32'h1);
    chk("redir_req",   {31'b0, imem_req}, 32'h1);
    drive(32'h21, 1'b1, 32'h20202020, 1'b0, 1'b0);
    step();
    chk("redir_addr2", imem_addr, 32'h84);
    chk("redir_tk2",   {31'b0, pc_taken}, 32'h1);
    chk("redir_valid", {31'b0, id_valid}, 32'h1);
    chk("redir_idpc",  id_pc, 32'h20);
    chk("redir_instr", id_instr, 32'h20202020);

    // Flush coincident with ack: data discarded, FIFO cleared, back to IDLE
    drive(32'h30, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b1);
    step();
    chk("fa_req",   {31'b0, imem_req}, 32'h0);
    chk("fa_state", {30'b0, dbg_state}, 32'h0);
    chk("fa_valid", {31'b0, id_valid}, 32'h0);
    chk("fa_taken", {31'b0, pc_taken}, 32'h0);
    chk("fa_idpc",  id_pc, 32'h20);
    chk("fa_instr", id_instr, 32'h20202020);
    drive(32'h30, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("fa_addr2",  imem_addr, 32'hC0);
    chk("fa_taken2", {31'b0, pc_taken}, 32'h1);
    drive(32'h31, 1'b1, 32'h30303030, 1'b0, 1'b0);
    step();
    chk("pre_valid", {31'b0, id_valid}, 32'h1);
    chk("pre_idpc",  id_pc, 32'h30);
    chk("pre_addr",  imem_addr, 32'hC4);

    // Asynchronous reset between edges while a request is outstanding
    #3 clr_n = 1'b0;
    #1;
    chk("ar_req",   {31'b0, imem_req}, 32'h0);
    chk("ar_valid", {31'b0, id_valid}, 32'h0);
    chk("ar_taken", {31'b0, pc_taken}, 32'h0);
    chk("ar_idpc",  id_pc, 32'h0);
    chk("ar_addr",  imem_addr, 32'h0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    drive(32'h40, 1'b1, 32'h77777777, 1'b0, 1'b0);
    step();
    chk("stale_valid", {31'b0, id_valid}, 32'h0);
    chk("stale_taken", {31'b0, pc_taken}, 32'h1);
    chk("stale_addr",  imem_addr, 32'h100);
    chk("stale_req",   {31'b0, imem_req}, 32'h1);
    drive(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("post_valid", {31'b0, id_valid}, 32'h0);
    chk("post_taken", {31'b0, pc_taken}, 32'h0);
    drive(32'h41, 1'b1, 32'h40404040, 1'b0, 1'b0);
    step();
    chk("post_valid2", {31'b0, id_valid}, 32'h1);
    chk("post_idpc",   id_pc, 32'h40);
    chk("post_instr",  id_instr, 32'h40404040);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage directly downstream of the program counter. It samples the word-address PC, runs a request/acknowledge transaction with instruction memory, and buffers returned instructions with their PCs in a small FIFO for decode. It returns a one-cycle `pc_taken` pulse so the PC stage advances only when the current PC has actually been issued. Branch/jump redirects arrive as `flush`, which discards wrong-path state.

Parameters:
DEPTH, 2, number of FIFO entries of {pc, instr}; power of two, at least 2.
BYTE_ADDR, 0, 0: imem_addr = pc_in (word address); 1: imem_addr = pc_in << 2, truncated to 32 bits.

Ports:
clk  input  1  clock; all state updates on posedge.
clr_n  input  1  asynchronous active-low reset.
pc_in  input  32  word address from PC stage; stable at posedge.
flush  input  1  redirect; discard FIFO, in-flight response and this cycle's pc_in.
pc_taken  output  1  registered; high for one cycle after the posedge at which pc_in was accepted.
imem_req  output  1  memory request valid.
imem_addr  output  32  memory address, held stable while imem_req is high.
imem_ack  input  1  memory response valid; sampled at posedge only while imem_req is high.
imem_rdata  input  32  instruction word; valid when imem_ack is high.
id_valid  output  1  FIFO head valid.
id_instr  output  32  FIFO head instruction.
id_pc  output  32  FIFO head PC (word address).
id_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Reset (clr_n low, asynchronous): state IDLE, FIFO empty, imem_req=0, imem_addr=0, pc_taken=0, id_valid=0, id_instr=0, id_pc=0. Deassertion is sampled normally at the next posedge.
- States:
  - IDLE: no request outstanding.
  - WAIT: imem_req=1, awaiting ack.
  - DROP: imem_req=1, awaiting ack for a flushed request; the data is discarded.
- Definitions used at each posedge:
  - pop = id_valid & id_ready & !flush.
  - push = imem_ack & (state==WAIT) & !flush.
  - occ_next = count + push - pop.
- accept = !flush & (state==IDLE | (state==WAIT & imem_ack)) & (occ_next < DEPTH).
- On accept:
  - imem_addr <= pc_in (or pc_in << 2); latch pc_in as the in-flight PC.
  - Next state is WAIT; pc_taken <= 1. Otherwise pc_taken <= 0.
- WAIT with ack and no accept → IDLE. WAIT with no ack → stay in WAIT; address held.
- Back-to-back: an ack with accept in the same cycle gives 1 fetch/cycle with zero-wait memory. The minimum request-to-ack latency is 1 cycle.
- Push writes {in-flight pc, imem_rdata} to the FIFO tail. The head appears on id_* the cycle after the push edge (no bypass).
- Pop advances the head. Simultaneous push and pop keeps count unchanged. Overflow is impossible because accept reserves the slot.
- id_instr/id_pc hold their last value when id_valid=0. Decode must qualify them with id_valid.
- Flush at a posedge:
  - FIFO cleared (id_valid=0 next cycle); no accept; pc_taken <= 0.
  - IDLE → IDLE.
  - WAIT without ack → DROP. WAIT with ack → IDLE; data discarded.
  - DROP stays in DROP until ack.
- DROP with ack → IDLE; data discarded; no accept on that edge. Flush while in DROP has no further effect.
- pc_in is ignored in DROP.
- Memory contract: once raised, imem_req and imem_addr do not change until the ack edge. In DROP, imem_req stays high until the ack.
- Reset mid-transaction abandons the request at once. Memory must tolerate imem_req dropping without an ack.
- Word arithmetic: the byte shift drops pc_in[31:30]. No other arithmetic is performed; PCs pass through unmodified.

Test Plan:
1. Reset check: hold clr_n=0 with arbitrary inputs → imem_req=0, pc_taken=0, id_valid=0, id_pc=0. Release with pc_in=0x0 → next posedge imem_req=1, imem_addr=0, pc_taken=1 for exactly one cycle.
2. Single fetch, 3-cycle ack latency: pc_in=0x10, BYTE_ADDR=1 → imem_addr=0x40 held 3 cycles. Then id_valid=1, id_pc=0x10, id_instr=rdata one cycle after the ack edge.
3. Zero-wait streaming: ack every cycle, id_ready=1, pc_in 0,1,2,3 → pc_taken high every cycle, id_pc sequence 0,1,2,3 on consecutive cycles, no bubbles.
4. Backpressure: id_ready=0, DEPTH=2, ack every cycle → exactly 2 pushes, then imem_req=0 and pc_taken=0. Raising id_ready for one cycle re-enables one fetch.
5. Flush cases:
   - Flush while WAIT (no ack): state DROP; a later ack with 0xDEADBEEF is never visible on id_*; next fetch uses the redirected pc_in=0x20.
   - Flush coincident with ack: data discarded, state IDLE.
6. Reset mid-WAIT: clr_n pulsed low asynchronously between edges → imem_req and id_valid drop immediately. A stale ack after release produces no push.
